// File: rtl/axis_dw_upsizer_if.sv
// axis_dw_upsizer_if: narrow input stream plus wide output stream of the upsizer.
interface axis_dw_upsizer_if #(
  parameter int IN_W  = 32,
  parameter int RATIO = 2
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int IKW   = IN_W / 8;
  localparam int OKW   = OUT_W / 8;
  logic [IN_W-1:0]  i_axis_data;
  logic [IKW-1:0]   i_axis_keep;
  logic             i_axis_valid;
  logic             i_axis_last;
  logic             o_axis_ready;
  logic [OUT_W-1:0] o_axis_data;
  logic [OKW-1:0]   o_axis_keep;
  logic             o_axis_valid;
  logic             o_axis_last;
  logic             i_axis_ready;
  modport slave (
    input  i_axis_data, i_axis_keep, i_axis_valid, i_axis_last, i_axis_ready,
    output o_axis_ready, o_axis_data, o_axis_keep, o_axis_valid, o_axis_last
  );
  modport master (
    output i_axis_data, i_axis_keep, i_axis_valid, i_axis_last, i_axis_ready,
    input  o_axis_ready, o_axis_data, o_axis_keep, o_axis_valid, o_axis_last
  );
endinterface

// File: rtl/axis_dw_upsizer.sv
// axis_dw_upsizer: packs RATIO IN_W-bit beats into one word, first beat in the MSB lanes.
// Defining DW_KEEP_CHK_EN adds o_keep_err, a registered pulse on malformed input keep.
module axis_dw_upsizer #(
  parameter int IN_W  = 32,
  parameter int RATIO = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
`ifdef DW_KEEP_CHK_EN
  output logic o_keep_err,
`endif
  axis_dw_upsizer_if.slave bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int IKW   = IN_W / 8;
  localparam int OKW   = OUT_W / 8;
  localparam int SW    = $clog2(RATIO);
  logic [SW-1:0]    slot_q, slot_d;
  logic [OUT_W-1:0] acc_data_q, acc_data_d, out_data_q, out_data_d, mrg_data;
  logic [OKW-1:0]   acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, mrg_keep;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             in_fire, done;
  assign bus.o_axis_ready = ~out_valid_q | bus.i_axis_ready;
  assign bus.o_axis_data  = out_data_q;
  assign bus.o_axis_keep  = out_keep_q;
  assign bus.o_axis_valid = out_valid_q;
  assign bus.o_axis_last  = out_last_q;
  assign in_fire = bus.i_axis_valid & bus.o_axis_ready;
  assign done    = in_fire & (bus.i_axis_last | (slot_q == SW'(RATIO - 1)));
  // Unwritten slots of the accumulator are always zero, so a short word needs no extra masking.
  always_comb begin
    mrg_data = acc_data_q;
    mrg_keep = acc_keep_q;
    for (int k = 0; k < RATIO; k++)
      if (slot_q == SW'(k)) begin
        mrg_data[OUT_W-1-k*IN_W -: IN_W] = bus.i_axis_data;
        mrg_keep[OKW-1-k*IKW -: IKW]     = bus.i_axis_keep;
      end
  end
  always_comb begin
    slot_d      = done ? '0 : in_fire ? slot_q + 1'b1 : slot_q;
    acc_data_d  = done ? '0 : in_fire ? mrg_data : acc_data_q;
    acc_keep_d  = done ? '0 : in_fire ? mrg_keep : acc_keep_q;
    out_valid_d = done | (out_valid_q & ~bus.i_axis_ready);
    out_data_d  = done ? mrg_data : out_data_q;
    out_keep_d  = done ? mrg_keep : out_keep_q;
    out_last_d  = done ? bus.i_axis_last : out_last_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      slot_q      <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
`ifdef DW_KEEP_CHK_EN
  logic [IKW-1:0] inv_keep;
  logic           keep_err_q, keep_err_d;
  assign inv_keep   = ~bus.i_axis_keep;
  assign o_keep_err = keep_err_q;
  // A last-beat keep is legal only as 1..10..0; its inverse is then 0..01..1.
  always_comb
    keep_err_d = in_fire & (bus.i_axis_last ? |(inv_keep & (inv_keep + 1'b1))
                                            : (bus.i_axis_keep != '1));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) keep_err_q <= 1'b0;
    else keep_err_q <= keep_err_d;
`endif
endmodule

// File: tb/tb_axis_dw_upsizer.sv
// tb_axis_dw_upsizer: directed scoreboard bench for RATIO=2 plus a RATIO=4 instance.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_axis_dw_upsizer;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } word_t;

  logic clk, rst_n;
  int checks = 0;
  int errors = 0;
  int last_wait = 0;
  word_t sb[$];

  axis_dw_upsizer_if #(.IN_W(32), .RATIO(2)) bus ();
  axis_dw_upsizer_if #(.IN_W(32), .RATIO(4)) bus4 ();
`ifdef DW_KEEP_CHK_EN
  logic keep_err, keep_err4;
`endif

  axis_dw_upsizer #(.IN_W(32), .RATIO(2)) u_dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
`ifdef DW_KEEP_CHK_EN
    .o_keep_err(keep_err),
`endif
    .bus(bus)
  );

  axis_dw_upsizer #(.IN_W(32), .RATIO(4)) u_dut4 (
    .i_clk(clk),
    .i_rst_n(rst_n),
`ifdef DW_KEEP_CHK_EN
    .o_keep_err(keep_err4),
`endif
    .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A = 32'hA1A1_0001, B = 32'hB2B2_0002, C = 32'hC3C3_0003, D = 32'hD4D4_0004;
  localparam logic [31:0] E = 32'hE5E5_0005, F = 32'hF6F6_0006, G = 32'h1717_0007, H = 32'h2828_0008;
  localparam logic [31:0] I = 32'h3939_0009, J = 32'h4A4A_000A, K = 32'h5B5B_000B, L = 32'h6C6C_000C;
  localparam logic [31:0] M = 32'h7D7D_000D, N = 32'h8E8E_000E, P = 32'h9F9F_000F, Q = 32'h1234_5678;
  localparam logic [31:0] R = 32'h8765_4321, S = 32'hDEAD_BEEF, T = 32'hCAFE_F00D, U = 32'h0BAD_CAFE;
  localparam logic [31:0] W = 32'h1357_9BDF, X = 32'h2468_ACE0, Y = 32'hFACE_0001, Z = 32'hFACE_0002;
  localparam logic [31:0] K7 = 32'h00AB_CDEF, L7 = 32'h5555_AAAA, Q4 = 32'h4444_0004;

  task automatic expect_word(input logic [63:0] d, input logic [7:0] k, input logic l);
    sb.push_back({d, k, l});
  endtask

  task automatic mon();
    word_t w;
    if (bus.o_axis_valid && bus.i_axis_ready) begin
      `CHK("sb_has_entry", sb.size() != 0, 1'b1)
      if (sb.size() != 0) begin
        w = sb.pop_front();
        `CHK("out_data", bus.o_axis_data, w.d)
        `CHK("out_keep", bus.o_axis_keep, w.k)
        `CHK("out_last", bus.o_axis_last, w.l)
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_axis_valid = 1'b0;
    bus.i_axis_last  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    bus.i_axis_data  = d;
    bus.i_axis_keep  = k;
    bus.i_axis_last  = l;
    bus.i_axis_valid = 1'b1;
    @(negedge clk);
    mon();
    while (!bus.o_axis_ready && n < 50) begin
      @(negedge clk);
      mon();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $error("FAIL accept_timeout waited=%0d cycles", n);
    end
    @(posedge clk);
    #1;
    last_wait = n;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_axis_data = '0; bus.i_axis_keep = '0; bus.i_axis_valid = 1'b0;
    bus.i_axis_last = 1'b0; bus.i_axis_ready = 1'b1;
    bus4.i_axis_data = '0; bus4.i_axis_keep = '0; bus4.i_axis_valid = 1'b0;
    bus4.i_axis_last = 1'b0; bus4.i_axis_ready = 1'b1;
    #3;
    checks++;
    if (bus.o_axis_valid !== 1'b0 || bus.o_axis_last !== 1'b0 || bus.o_axis_data !== 64'h0 ||
        bus.o_axis_keep !== 8'h0 || bus.o_axis_ready !== 1'b1 || bus4.o_axis_data !== 128'h0) begin
      errors++;
      $error("FAIL reset_state valid=%0b last=%0b data=%0h keep=%0h ready=%0b data4=%0h",
             bus.o_axis_valid, bus.o_axis_last, bus.o_axis_data, bus.o_axis_keep,
             bus.o_axis_ready, bus4.o_axis_data);
    end
`ifdef DW_KEEP_CHK_EN
    `CHK("rst_keep_err", keep_err, 1'b0)
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_word({A, B}, 8'hFF, 1'b0);
    expect_word({C, D}, 8'hFF, 1'b1);
    beat(A, 4'hF, 1'b0);
    `CHK("t1_wait_a", last_wait, 0)
    `CHK("t1_no_early_valid", bus.o_axis_valid, 1'b0)
    beat(B, 4'hF, 1'b0);
    `CHK("t1_wait_b", last_wait, 0)
    `CHK("t1_valid_ab", bus.o_axis_valid, 1'b1)
    `CHK("t1_data_ab", bus.o_axis_data, {A, B})
    beat(C, 4'hF, 1'b0);
    `CHK("t1_wait_c", last_wait, 0)
    `CHK("t1_drained", bus.o_axis_valid, 1'b0)
    beat(D, 4'hF, 1'b1);
    `CHK("t1_wait_d", last_wait, 0)
    `CHK("t1_valid_cd", bus.o_axis_valid, 1'b1)
    `CHK("t1_last_cd", bus.o_axis_last, 1'b1)
    idle();
    tick();
    `CHK("t1_idle", bus.o_axis_valid, 1'b0)

    expect_word({E, F}, 8'hFF, 1'b0);
    expect_word({G, 32'h0}, 8'hC0, 1'b1);
    expect_word({H, I}, 8'hFF, 1'b1);
    beat(E, 4'hF, 1'b0);
    beat(F, 4'hF, 1'b0);
    beat(G, 4'b1100, 1'b1);
    `CHK("t2_short_data", bus.o_axis_data, {G, 32'h0})
    `CHK("t2_short_keep", bus.o_axis_keep, 8'hC0)
    beat(H, 4'hF, 1'b0);
    `CHK("t2_h_is_slot0", bus.o_axis_valid, 1'b0)
    beat(I, 4'hF, 1'b1);
    `CHK("t2_data_hi", bus.o_axis_data, {H, I})
    idle();
    tick();

    expect_word({P, 32'h0}, 8'hF0, 1'b1);
    expect_word({Q, 32'h0}, 8'hF0, 1'b1);
    expect_word({R, 32'h0}, 8'hF0, 1'b1);
    beat(P, 4'hF, 1'b1);
    `CHK("t3_keep_slot0_last", bus.o_axis_keep, 8'hF0)
    beat(Q, 4'hF, 1'b1);
    `CHK("t3_wait_q", last_wait, 0)
    `CHK("t3_refill_valid", bus.o_axis_valid, 1'b1)
    `CHK("t3_refill_data", bus.o_axis_data, {Q, 32'h0})
    beat(R, 4'hF, 1'b1);
    `CHK("t3_wait_r", last_wait, 0)
    idle();
    tick();

    expect_word({K7, L7}, 8'h7F, 1'b1);
    expect_word({N, 32'h0}, 8'hA0, 1'b1);
    beat(K7, 4'b0111, 1'b0);
`ifdef DW_KEEP_CHK_EN
    `CHK("kc_err_nonlast", keep_err, 1'b1)
`endif
    beat(L7, 4'hF, 1'b1);
`ifdef DW_KEEP_CHK_EN
    `CHK("kc_err_pulse_end", keep_err, 1'b0)
`endif
    `CHK("kc_keep_passthru", bus.o_axis_keep, 8'h7F)
    `CHK("kc_data_passthru", bus.o_axis_data, {K7, L7})
    beat(N, 4'b1010, 1'b1);
`ifdef DW_KEEP_CHK_EN
    `CHK("kc_err_noncontig", keep_err, 1'b1)
`endif
    idle();
    tick();
`ifdef DW_KEEP_CHK_EN
    `CHK("kc_err_clear", keep_err, 1'b0)
`endif

    bus.i_axis_ready = 1'b0;
    expect_word({J, K}, 8'hFF, 1'b0);
    expect_word({L, M}, 8'hFF, 1'b1);
    beat(J, 4'hF, 1'b0);
    beat(K, 4'hF, 1'b0);
    bus.i_axis_data = L; bus.i_axis_keep = 4'hF; bus.i_axis_last = 1'b0; bus.i_axis_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      mon();
      `CHK("bp_ready_low", bus.o_axis_ready, 1'b0)
      `CHK("bp_valid_held", bus.o_axis_valid, 1'b1)
      `CHK("bp_data_held", bus.o_axis_data, {J, K})
      `CHK("bp_last_held", bus.o_axis_last, 1'b0)
    end
    @(posedge clk); #1;
    bus.i_axis_ready = 1'b1;
    beat(L, 4'hF, 1'b0);
    `CHK("bp_wait_l", last_wait, 0)
    beat(M, 4'hF, 1'b1);
    `CHK("bp_wait_m", last_wait, 0)
    `CHK("bp_data_lm", bus.o_axis_data, {L, M})
    idle();
    tick();

    bus.i_axis_ready = 1'b0;
    beat(T, 4'hF, 1'b0);
    beat(U, 4'hF, 1'b0);
    idle();
    `CHK("rs_pending", bus.o_axis_valid, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("rs_valid", bus.o_axis_valid, 1'b0)
    `CHK("rs_data", bus.o_axis_data, 64'h0)
    `CHK("rs_keep", bus.o_axis_keep, 8'h0)
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.i_axis_ready = 1'b1;
    @(posedge clk); #1;
    beat(S, 4'hF, 1'b0);
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    `CHK("rs2_valid", bus.o_axis_valid, 1'b0)
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    expect_word({W, X}, 8'hFF, 1'b1);
    beat(W, 4'hF, 1'b0);
    `CHK("rs_w_is_slot0", bus.o_axis_valid, 1'b0)
    beat(X, 4'hF, 1'b1);
    `CHK("rs_data_wx", bus.o_axis_data, {W, X})
    `CHK("rs_keep_wx", bus.o_axis_keep, 8'hFF)
    idle();
    tick();

    bus4.i_axis_data = Y; bus4.i_axis_keep = 4'hF; bus4.i_axis_last = 1'b0; bus4.i_axis_valid = 1'b1;
    @(posedge clk); #1;
    bus4.i_axis_data = Z; bus4.i_axis_last = 1'b1;
    @(posedge clk); #1;
    bus4.i_axis_valid = 1'b0; bus4.i_axis_last = 1'b0;
    `CHK("r4_valid", bus4.o_axis_valid, 1'b1)
    `CHK("r4_data", bus4.o_axis_data, {Y, Z, 64'h0})
    `CHK("r4_keep", bus4.o_axis_keep, 16'hFF00)
    `CHK("r4_last", bus4.o_axis_last, 1'b1)
    bus4.i_axis_data = Q4; bus4.i_axis_keep = 4'hF; bus4.i_axis_last = 1'b1; bus4.i_axis_valid = 1'b1;
    @(posedge clk); #1;
    bus4.i_axis_valid = 1'b0; bus4.i_axis_last = 1'b0;
    `CHK("r4_single_data", bus4.o_axis_data, {Q4, 96'h0})
    `CHK("r4_single_keep", bus4.o_axis_keep, 16'hF000)
    @(posedge clk); #1;
    `CHK("r4_drained", bus4.o_axis_valid, 1'b0)

    `CHK("sb_empty", sb.size(), 0)
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_dw_upsizer.md
Name: axis_dw_upsizer

Overview:
- Parametrised AXI-Stream width up-converter for the 8b10b GT receive path: packs RATIO consecutive IN_W-bit beats into one OUT_W = IN_W*RATIO bit beat.
- Successor to the fixed 32-to-64 packer; adds variable ratio, true downstream backpressure (i_ready / o_ready), correct keep for short frames, and frame-aligned packing.
- Sits between the GT 8b10b framer (user clock domain) and the wide PCIe-side datapath.

Parameters:
- IN_W, 32, input data width in bits; multiple of 8.
- RATIO, 2, beats packed per output word; legal values 2, 4, 8.
- OUT_W (localparam), IN_W*RATIO, output data width.
- IKW / OKW (localparams), IN_W/8 and OUT_W/8, keep widths.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_axis_data  in  IN_W  input beat data
- i_axis_keep  in  IKW  input byte enables; all ones except on the last beat
- i_axis_valid  in  1  input beat valid
- i_axis_last  in  1  final beat of frame
- o_axis_ready  out  1  upstream may transfer
- o_axis_data  out  OUT_W  packed word
- o_axis_keep  out  OKW  packed byte enables
- o_axis_valid  out  1  packed word valid
- o_axis_last  out  1  final word of frame
- i_axis_ready  in  1  downstream accepts

Behaviour:
- Reset (async assert, sync release): o_axis_valid=0, o_axis_last=0, o_axis_data=0, o_axis_keep=0; slot index=0; accumulator cleared.
- Input transfer occurs when i_axis_valid & o_axis_ready.
- o_axis_ready = ~o_axis_valid | i_axis_ready, combinational from the output register state. Full throughput when the downstream is always ready.
- Lane order: beat k of a word (k = 0..RATIO-1) lands in bits [OUT_W-1-k*IN_W -: IN_W] and keep [OKW-1-k*IKW -: IKW]. The first beat goes in the MSB lanes.
- Accumulator:
  - Accepted beat writes slot k.
  - Slot index increments on each accepted beat.
  - Slot index resets to 0 on an accepted beat with k==RATIO-1, or with i_axis_last=1.
- Completion: an accepted beat with k==RATIO-1 or last=1 completes a word.
  - On the next clock, o_axis_valid=1.
  - o_axis_data = accumulator with this beat merged in; slots above k are forced to data 0 and keep 0.
  - o_axis_last = i_axis_last of the completing beat.
  - Latency: 1 cycle from the completing input transfer to o_axis_valid.
- Output hold: while o_axis_valid & ~i_axis_ready, all outputs are held stable and o_axis_ready=0.
- Drain and refill: when i_axis_ready=1 in the same cycle a new word completes, the output register reloads with no bubble. Otherwise o_axis_valid drops after the handshake.
- Accumulator clearing: after each completion, accumulator data and keep clear to 0, so no stale bytes leak into a short word.
- Frames never share an output word. last on slot 0 gives a word with only the top IKW keep bits set.
- i_axis_valid low mid-word: slot index and accumulator hold indefinitely; no timeout.
- Reset mid-word or mid-hold: partial word and pending output are discarded; the first beat after reset starts at slot 0.
- The keep of a non-last input beat is passed through unmodified.

Optional Feature:
- Macro: DW_KEEP_CHK_EN.
- Defined:
  - Adds output port o_keep_err (1 bit, reset 0).
  - o_keep_err pulses high for 1 cycle, registered, when an accepted beat has i_axis_last=0 and i_axis_keep != all ones.
  - o_keep_err also pulses when an accepted last beat has non-contiguous keep (a 0 above a 1, MSB-first).
  - Data path is unaffected.
- Undefined: port and checker logic are absent; behaviour otherwise identical.

Test Plan:
- RATIO=2, ready=1, 4 beats A,B,C,D, last on D -> words {A,B} keep FF last 0, then {C,D} keep FF last 1, each 1 cycle after its completing beat, no bubbles.
- RATIO=2, 3-beat frame A,B,C with C keep=4'b1100, last -> second word {C,32'h0} keep 8'b1100_0000, last 1; the next frame starts at slot 0.
- RATIO=4, 2-beat frame keep F,F last -> one word with data in [127:64], keep 16'hFF00, last 1.
- RATIO=2, i_axis_ready held 0 for 5 cycles with output valid -> o_axis_ready=0, outputs stable; on release, the word transfers and the next word follows back-to-back.
- Reset asserted after 1 beat of a word -> all outputs 0 immediately; a post-reset frame packs from slot 0 with no residue from the pre-reset beat.
- DW_KEEP_CHK_EN, non-last beat keep=4'b0111 -> o_keep_err=1 for exactly one cycle; packed data still contains the beat unchanged.
